// File: rtl/div64_iter.sv
// Iterative radix-2 restoring divider (signed/unsigned) with valid/ready on both sides.
// One quotient bit per cycle, MSB first; sign fix-up happens in a single cycle afterwards.
module div64_iter #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q;
  logic              in_ready_q, out_valid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   rem_q, quo_q, dvsr_q;
  logic              q_neg_q, r_neg_q;
  logic [XLEN-1:0]   quotient_q, remainder_q;
  logic              dbz_q;

  logic              a_neg_d, b_neg_d, ovf_d;
  logic [XLEN-1:0]   abs_a_d, abs_b_d;
  logic [XLEN:0]     shift_d, trial_d;

  assign a_neg_d = is_signed & dividend[XLEN-1];
  assign b_neg_d = is_signed & divisor[XLEN-1];
  // Negating MIN_NEG yields MIN_NEG, which is exactly 2^(XLEN-1) read as unsigned.
  assign abs_a_d = a_neg_d ? -dividend : dividend;
  assign abs_b_d = b_neg_d ? -divisor : divisor;
  assign ovf_d   = is_signed && (dividend == MIN_NEG) && (divisor == '1);

  // The remainder is always below the divisor, so the top bit of trial is a clean borrow.
  assign shift_d = {rem_q, quo_q[XLEN-1]};
  assign trial_d = shift_d - {1'b0, dvsr_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (divisor == '0) begin
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (ovf_d) begin
              quotient_q  <= dividend;
              remainder_q <= '0;
              dbz_q       <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              rem_q   <= '0;
              quo_q   <= abs_a_d;
              dvsr_q  <= abs_b_d;
              q_neg_q <= a_neg_d ^ b_neg_d;
              r_neg_q <= a_neg_d;
              cnt_q   <= CNT_W'(XLEN);
              dbz_q   <= 1'b0;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (!trial_d[XLEN]) begin
            rem_q <= trial_d[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_q <= shift_d[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b0};
          end
          if (cnt_q == CNT_W'(1)) state_q <= FIX;
        end
        FIX: begin
          quotient_q  <= q_neg_q ? -quo_q : quo_q;
          remainder_q <= r_neg_q ? -rem_q : rem_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div64_iter.sv
// Self-checking bench for div64_iter: directed corner cases plus randomized operands
// checked every valid cycle against an arithmetic reference model.
module tb_div64_iter;

  localparam int XLEN = 64;
  localparam int NORM_LAT = XLEN + 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] dividend = '0;
  logic [XLEN-1:0] divisor = '0;
  logic            is_signed = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;
  logic            div_by_zero;

  div64_iter #(.XLEN(XLEN), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    bit          s;
    int          e0;
  } op_t;

  op_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  n_retired = 0;
  int  ready_mode = 0;  // 0: always ready, 1: random stalls, 2: held off
  logic [63:0] last_q, last_r;
  logic        last_z;
  int          last_lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division with the two RISC-V special cases.
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input bit s,
                                output logic [63:0] q, output logic [63:0] r, output bit z);
    longint sa, sb;
    z = 1'b0;
    if (b == 64'd0) begin
      q = '1; r = a; z = 1'b1;
    end else if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
      q = a; r = 64'd0;
    end else if (s) begin
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  function automatic int model_lat(input logic [63:0] a, input logic [63:0] b, input bit s);
    if (b == 64'd0) return 1;
    if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return 1;
    return NORM_LAT;
  endfunction

  function automatic logic [63:0] mag(input logic [63:0] v, input bit s);
    return (s && v[63]) ? -v : v;
  endfunction

  // Compare process: every cycle out_valid is high, outputs must match the head op.
  initial begin
    bit seen = 1'b0;
    op_t e;
    logic [63:0] eq, er;
    bit ez;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        seen = 1'b0;
        continue;
      end
      if (out_valid) begin
        chk("in_ready_in_done", {63'd0, in_ready}, 64'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          e = exp_q[0];
          model(e.a, e.b, e.s, eq, er, ez);
          chk("quotient", quotient, eq);
          chk("remainder", remainder, er);
          chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, ez});
          if (!seen) begin
            seen = 1'b1;
            last_lat = cyc - e.e0 + 1;
            chk("latency", 64'(last_lat), 64'(model_lat(e.a, e.b, e.s)));
            if (!ez)
              chk("rem_magnitude", {63'd0, mag(remainder, e.s) < mag(e.b, e.s)}, 64'd1);
          end
          if (out_ready) begin
            last_q = quotient; last_r = remainder; last_z = div_by_zero;
            $display("txn %0d: a=%h b=%h s=%0d q=%h r=%h z=%0d lat=%0d",
                     n_retired, e.a, e.b, e.s, quotient, remainder, div_by_zero, last_lat);
            void'(exp_q.pop_front());
            seen = 1'b0;
            n_retired++;
          end
        end
      end
    end
  end

  // Sole driver of out_ready.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic issue_op(input logic [63:0] a, input logic [63:0] b, input bit s);
    int i;
    @(posedge clk);
    #1;
    dividend = a; divisor = b; is_signed = s; in_valid = 1'b1;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (i == 300) chk("accept_timeout", 64'd0, 64'd1);
    exp_q.push_back('{a: a, b: b, s: s, e0: cyc + 1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = {$urandom, $urandom};
    divisor = {$urandom, $urandom};
    is_signed = $urandom_range(0, 1);
  endtask

  task automatic wait_retire(input int prev);
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (n_retired > prev) break;
    end
    if (i == 2000) chk("retire_timeout", 64'd0, 64'd1);
  endtask

  task automatic directed(input logic [63:0] a, input logic [63:0] b, input bit s,
                          input logic [63:0] eq, input logic [63:0] er, input bit ez, input int elat);
    int prev;
    prev = n_retired;
    issue_op(a, b, s);
    wait_retire(prev);
    chk("lit_quotient", last_q, eq);
    chk("lit_remainder", last_r, er);
    chk("lit_dbz", {63'd0, last_z}, {63'd0, ez});
    chk("lit_latency", 64'(last_lat), 64'(elat));
  endtask

  initial begin
    logic [63:0] mq, mr, snap_q, snap_r, a, b;
    bit mz, s;
    int prev, i, k;

    // Pin the reference model with hand-computed results.
    model(64'd100, 64'd7, 1'b0, mq, mr, mz);
    chk("model_u_q", mq, 64'd14);
    chk("model_u_r", mr, 64'd2);
    model(-64'd100, 64'd7, 1'b1, mq, mr, mz);
    chk("model_s_q", mq, 64'hFFFF_FFFF_FFFF_FFF2);
    chk("model_s_r", mr, 64'hFFFF_FFFF_FFFF_FFFE);
    model(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, mq, mr, mz);
    chk("model_ovf_u_q", mq, 64'd0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_quotient", quotient, 64'd0);
    chk("rst_remainder", remainder, 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);

    directed(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0, 66);
    directed(-64'd100, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 66);
    directed(64'd100, -64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0, 66);
    directed(64'h1234, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 1);
    directed(64'h1234, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 1);
    directed(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
             64'h8000_0000_0000_0000, 64'd0, 1'b0, 1);
    directed(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
             64'd0, 64'h8000_0000_0000_0000, 1'b0, 66);

    // Back-pressure: hold the result for 20 cycles.
    ready_mode = 2;
    prev = n_retired;
    issue_op(64'hDEAD_BEEF_1234_5678, 64'd1000, 1'b0);
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    if (i == 200) chk("bp_valid_timeout", 64'd0, 64'd1);
    snap_q = quotient; snap_r = remainder;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("bp_hold_q", quotient, snap_q);
      chk("bp_hold_r", remainder, snap_r);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    end
    ready_mode = 0;
    wait_retire(prev);
    chk("bp_lit_q", last_q, 64'hDEAD_BEEF_1234_5678 / 64'd1000);

    // Reset in the middle of RUN: result must vanish.
    prev = n_retired;
    issue_op(64'h0123_4567_89AB_CDEF, 64'd77, 1'b0);
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    repeat (80) @(negedge clk);
    chk("midrst_no_retire", 64'(n_retired), 64'(prev));
    directed(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 64'h5555_5555_5555_5555, 64'd0, 1'b0, 66);

    // Randomized regression with output stalls.
    ready_mode = 1;
    for (i = 0; i < 600; i++) begin
      s = $urandom_range(0, 1);
      a = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) a = -a;
      case ($urandom_range(0, 9))
        0: b = 64'd0;
        1: begin a = 64'h8000_0000_0000_0000; b = 64'hFFFF_FFFF_FFFF_FFFF; end
        2: b = 64'($urandom_range(1, 15));
        default: begin
          b = {$urandom, $urandom} >> $urandom_range(0, 63);
          if ($urandom_range(0, 1) == 1) b = -b;
        end
      endcase
      issue_op(a, b, s);
    end
    ready_mode = 0;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (i == 2000) chk("drain_timeout", 64'd0, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
